// File: rtl/riscv_seq_alu.sv
`timescale 1ns/1ps
// riscv_seq_alu
// Handshaked ALU between register read and writeback. Logic, add, subtract
// and unsigned set-less-than complete one cycle after accept. When
// RISCV_SEQ_ALU_MULDIV_EN is defined, unsigned multiply (8), divide (9) and
// remainder (10) run iteratively over WIDTH cycles. Without it those codes
// return 0 after one cycle and busy is tied low.
//
// Ports:
//   clock, reset_n      rising-edge clock, async active-low reset
//   in_valid/in_ready   request handshake; ALUctl, A, B sampled on accept
//   out_valid/out_ready result handshake; ALUOut/Zero held while out_valid
//   ALUOut, Zero        registered result and (result == 0)
//   busy                high while iterating in MUL or DIV
module riscv_seq_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] aluout_n;
  logic [WIDTH-1:0] simple_res;
  logic             accept;

  assign in_ready  = reset_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  always_comb begin
    simple_res = '0;
    case (ALUctl)
      4'd0:    simple_res = A & B;
      4'd1:    simple_res = A | B;
      4'd2:    simple_res = A + B;
      4'd6:    simple_res = A - B;
      4'd7:    simple_res = (A < B) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      4'd12:   simple_res = ~(A | B);
      default: simple_res = '0;
    endcase
  end

`ifdef RISCV_SEQ_ALU_MULDIV_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [3:0]       op, op_n;
  logic [WIDTH-1:0] opa, opa_n;   // MUL: shifted multiplicand; DIV: dividend -> quotient
  logic [WIDTH-1:0] opb, opb_n;   // MUL: shifted multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc, acc_n;   // MUL: partial product;      DIV: partial remainder
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [WIDTH-1:0] sa, sb, sacc;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_tmp;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem, div_q;

  // The first iteration runs on the accept edge straight from the inputs, so
  // WIDTH iterations fit in accept + WIDTH-1 cycles of MUL/DIV. cnt tracks the
  // remaining iterations; the one at cnt==0 writes the result.
  assign sa   = accept ? A  : opa;
  assign sb   = accept ? B  : opb;
  assign sacc = accept ? '0 : acc;

  assign mul_acc = sacc + (sb[0] ? sa : '0);
  assign div_tmp = {sacc, sa[WIDTH-1]};
  assign div_ge  = (div_tmp >= {1'b0, sb});
  assign div_rem = div_ge ? WIDTH'(div_tmp - {1'b0, sb}) : div_tmp[WIDTH-1:0];
  assign div_q   = {sa[WIDTH-2:0], div_ge};

  assign busy = (state == MUL) || (state == DIV);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    aluout_n = ALUOut;
`ifdef RISCV_SEQ_ALU_MULDIV_EN
    op_n  = op;
    opa_n = opa;
    opb_n = opb;
    acc_n = acc;
    cnt_n = cnt;
`endif
    if (accept) begin
      state_n  = DONE;
      aluout_n = simple_res;
`ifdef RISCV_SEQ_ALU_MULDIV_EN
      op_n = ALUctl;
      if (ALUctl == 4'd8) begin
        state_n = MUL;
        opa_n   = sa << 1;
        opb_n   = sb >> 1;
        acc_n   = mul_acc;
        cnt_n   = CNT_W'(WIDTH - 2);
      end else if ((ALUctl == 4'd9) || (ALUctl == 4'd10)) begin
        if (B == '0) begin
          aluout_n = (ALUctl == 4'd9) ? '1 : A;
        end else begin
          state_n = DIV;
          opa_n   = div_q;
          opb_n   = sb;
          acc_n   = div_rem;
          cnt_n   = CNT_W'(WIDTH - 2);
        end
      end
`endif
    end else begin
      case (state)
        DONE: if (out_ready) state_n = IDLE;
`ifdef RISCV_SEQ_ALU_MULDIV_EN
        MUL: begin
          opa_n = sa << 1;
          opb_n = sb >> 1;
          acc_n = mul_acc;
          if (cnt == '0) begin
            aluout_n = mul_acc;
            state_n  = DONE;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        DIV: begin
          opa_n = div_q;
          acc_n = div_rem;
          if (cnt == '0) begin
            aluout_n = (op == 4'd9) ? div_q : div_rem;
            state_n  = DONE;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ALUOut <= '0;
      Zero   <= 1'b1;
`ifdef RISCV_SEQ_ALU_MULDIV_EN
      op  <= '0;
      opa <= '0;
      opb <= '0;
      acc <= '0;
      cnt <= '0;
`endif
    end else begin
      state  <= state_n;
      ALUOut <= aluout_n;
      Zero   <= (aluout_n == '0);
`ifdef RISCV_SEQ_ALU_MULDIV_EN
      op  <= op_n;
      opa <= opa_n;
      opb <= opb_n;
      acc <= acc_n;
      cnt <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_seq_alu.sv
`timescale 1ns/1ps
module tb_riscv_seq_alu;

  localparam int W = 64;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUctl;
  logic [W-1:0] A, B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUOut;
  logic         Zero;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_seq_alu #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUctl   (ALUctl),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUOut   (ALUOut),
    .Zero     (Zero),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op (out_ready high) and count edges until out_valid, the
  // cycles busy was seen high, and cycles in_ready was wrongly high.
  task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt, output int rdy_bad);
    ALUctl = ctl; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; A = '0; B = '0; ALUctl = 4'd0;
    lat = 1; busy_cnt = 0; rdy_bad = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cnt++;
      if (in_ready) rdy_bad++;
      tick();
      lat++;
    end
  endtask

  // Single-cycle op back-to-back with out_ready high.
  task automatic one(input string tag, input logic [3:0] ctl, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp);
    ALUctl = ctl; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk({tag, "_valid"}, W'(out_valid), W'(1));
    chk(tag, ALUOut, exp);
    chk({tag, "_zero"}, W'(Zero), W'(exp == '0));
  endtask

  initial begin
    int lat, bc, rb, seen;
    logic [W-1:0] ones;
    ones = '1;

    // Reset with a pending request
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    ALUctl = 4'd2; A = 64'd9; B = 64'd9;
    tick(); tick();
    chk("rst_in_ready",  W'(in_ready),  W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_aluout",    ALUOut,        '0);
    chk("rst_zero",      W'(Zero),      W'(1));
    chk("rst_busy",      W'(busy),      W'(0));
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk("rel_in_ready", W'(in_ready), W'(1));
    tick();
    chk("rel_in_ready2", W'(in_ready), W'(1));

    // Back-to-back single-cycle ops
    one("sub_5_3",   4'd6,  64'd5, 64'd3, 64'd2);
    chk("b2b_ready", W'(in_ready), W'(1));
    one("sub_3_3",   4'd6,  64'd3, 64'd3, 64'd0);
    one("sub_0_1",   4'd6,  64'd0, 64'd1, ones);
    one("slt_1_2",   4'd7,  64'd1, 64'd2, 64'd1);
    one("slt_2_1",   4'd7,  64'd2, 64'd1, 64'd0);
    one("slt_unsig", 4'd7,  ones,  64'd1, 64'd0);
    one("code13",    4'd13, 64'd5, 64'd3, 64'd0);
    one("and",       4'd0,  64'hF0F0, 64'hFF00, 64'hF000);
    one("or",        4'd1,  64'hF0F0, 64'hFF00, 64'hFFF0);
    one("add",       4'd2,  64'hF0F0, 64'hFF00, 64'h1EFF0);
    one("add_wrap",  4'd2,  ones,     64'd1,    64'd0);
    one("nor",       4'd12, 64'hF0F0, 64'hFF00, 64'hFFFF_FFFF_FFFF_000F);

    // Backpressure after an ADD result
    one("bp_add", 4'd2, 64'd10, 64'd20, 64'd30);
    in_valid = 1'b1; ALUctl = 4'd0; A = 64'd0; B = 64'd0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_aluout", ALUOut, 64'd30);
      chk("bp_valid",  W'(out_valid), W'(1));
      chk("bp_ready",  W'(in_ready),  W'(0));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release_valid", W'(out_valid), W'(0));
    chk("bp_release_hold",  ALUOut, 64'd30);

`ifdef RISCV_SEQ_ALU_MULDIV_EN
    // MUL
    run_op(4'd8, 64'hFFFF_FFFF, 64'h1_0000_0001, lat, bc, rb);
    chk("mul_lat",   W'(lat), W'(64));
    chk("mul_busy",  W'(bc),  W'(63));
    chk("mul_ready", W'(rb),  W'(0));
    chk("mul_res",   ALUOut,  ones);
    chk("mul_zero",  W'(Zero), W'(0));
    tick();

    run_op(4'd8, 64'd6, 64'd7, lat, bc, rb);
    chk("mul67_lat", W'(lat), W'(64));
    chk("mul67_res", ALUOut,  64'd42);
    tick();

    // DIV / REM
    run_op(4'd9, 64'd100, 64'd7, lat, bc, rb);
    chk("divu_lat",  W'(lat), W'(64));
    chk("divu_busy", W'(bc),  W'(63));
    chk("divu_res",  ALUOut,  64'd14);
    tick();
    run_op(4'd10, 64'd100, 64'd7, lat, bc, rb);
    chk("remu_lat", W'(lat), W'(64));
    chk("remu_res", ALUOut,  64'd2);
    tick();
    run_op(4'd9, ones, 64'd1, lat, bc, rb);
    chk("divu_big", ALUOut, ones);
    tick();
    run_op(4'd10, 64'd7, 64'd100, lat, bc, rb);
    chk("remu_small", ALUOut, 64'd7);
    tick();

    // Divide by zero
    run_op(4'd9, 64'd42, 64'd0, lat, bc, rb);
    chk("div0_lat",  W'(lat), W'(1));
    chk("div0_busy", W'(bc),  W'(0));
    chk("div0_res",  ALUOut,  ones);
    tick();
    run_op(4'd10, 64'd42, 64'd0, lat, bc, rb);
    chk("rem0_lat", W'(lat), W'(1));
    chk("rem0_res", ALUOut,  64'd42);
    tick();

    // Abort a MUL with reset at cycle 20
    ALUctl = 4'd8; A = 64'd3; B = 64'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("abort_busy_before", W'(busy), W'(1));
    reset_n = 1'b0;
    #1;
    chk("abort_valid", W'(out_valid), W'(0));
    chk("abort_busy",  W'(busy),      W'(0));
    chk("abort_out",   ALUOut,        '0);
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    chk("abort_never_valid", W'(seen), W'(0));
    one("abort_next_add", 4'd2, 64'd7, 64'd8, 64'd15);
    run_op(4'd8, 64'd3, 64'd5, lat, bc, rb);
    chk("abort_next_mul_lat", W'(lat), W'(64));
    chk("abort_next_mul",     ALUOut,  64'd15);
    tick();
`else
    // MUL/DIV disabled: codes 8/9/10 take the default path
    run_op(4'd8, 64'd3, 64'd4, lat, bc, rb);
    chk("nomul_lat",  W'(lat),  W'(1));
    chk("nomul_busy", W'(bc),   W'(0));
    chk("nomul_res",  ALUOut,   64'd0);
    chk("nomul_zero", W'(Zero), W'(1));
    tick();
    run_op(4'd9, 64'd42, 64'd0, lat, bc, rb);
    chk("nodiv_lat", W'(lat), W'(1));
    chk("nodiv_res", ALUOut,  64'd0);
    tick();
    run_op(4'd10, 64'd100, 64'd7, lat, bc, rb);
    chk("norem_res", ALUOut, 64'd0);
    tick();

    // Reset while a result is pending
    ALUctl = 4'd2; A = 64'd1; B = 64'd1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_valid", W'(out_valid), W'(0));
    chk("abort_out",   ALUOut,        '0);
    tick();
    reset_n = 1'b1;
    one("abort_next_add", 4'd2, 64'd7, 64'd8, 64'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
